if_id_queue: RTL

//   Receiving end of the fetch-stage output (pc, inst). Buffers fetched instructions in a

---
 rtl/if_id_queue_pkg.sv | 15 +
 rtl/if_id_queue_mem.sv | 34 +++
 rtl/if_id_queue.sv | 88 ++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// ============================================================================
// Module  : if_id_queue_pkg
// Purpose : Shared word width and NOP encoding for the IF/ID instruction queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package if_id_queue_pkg;

    localparam int          c_WORD_WIDTH = 32;
    localparam logic [31:0] c_NOP_INST   = 32'h0;

endpackage

`default_nettype wire

// File: rtl/if_id_queue_mem.sv
// ============================================================================
// Module  : if_id_queue_mem
// Purpose : DEPTH x DW register array, synchronous write and asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue_mem #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // Contents are deliberately left unreset; occupancy is tracked by the owner.
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
// ============================================================================
// Module  : if_id_queue
// Purpose : Fall-through FIFO between fetch and decode with freeze and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int WIDTH = c_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_inst,
    input  logic             flush,
    input  logic             id_stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_inst,
    output logic             if_freeze,
    output logic [AW:0]      count
);

    localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]      r_rdPtr;
    logic [AW-1:0]      r_wrPtr;
    logic [AW:0]        r_count;
    logic               w_full;
    logic               w_nonEmpty;
    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_rdata;

    // Status derives only from registered count, so no id_stall path reaches IF.
    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_nonEmpty = (r_count != '0);
    assign w_push     = in_valid & ~w_full & ~flush;
    assign w_pop      = w_nonEmpty & ~id_stall & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (2*WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wrPtr),
        .wdata ({in_pc, in_inst}),
        .raddr (r_rdPtr),
        .rdata (w_rdata)
    );

    // Empty queue presents a NOP bubble rather than stale storage.
    assign out_valid = w_nonEmpty;
    assign out_pc    = w_nonEmpty ? w_rdata[2*WIDTH-1:WIDTH] : '0;
    assign out_inst  = w_nonEmpty ? w_rdata[WIDTH-1:0] : WIDTH'(c_NOP_INST);
    assign if_freeze = w_full;
    assign count     = r_count;

endmodule

`default_nettype wire
